// File: rtl/axi4_stream_pkt_fifo_v2.sv
// ============================================================================
// Module   : axi4_stream_pkt_fifo_v2
// Brief    : Single-clock AXI4-Stream packet FIFO (passthrough / store-and-forward)
// Revision : 2.0
// ============================================================================
`default_nettype none

module axi4_stream_pkt_fifo_v2 #(
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 1,
    parameter int DEST_WIDTH      = 1,
    parameter int ID_WIDTH        = 1,
    parameter int WORDS_AMOUNT    = 8,
    parameter int MODE            = 1,
    parameter int ALMOST_FULL_LVL = WORDS_AMOUNT - 2,
    localparam int ADDR_WIDTH     = $clog2(WORDS_AMOUNT),
    localparam int KEEP_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  pkt_i_tvalid,
    output logic                  pkt_i_tready,
    input  logic [DATA_WIDTH-1:0] pkt_i_tdata,
    input  logic [KEEP_WIDTH-1:0] pkt_i_tstrb,
    input  logic [KEEP_WIDTH-1:0] pkt_i_tkeep,
    input  logic                  pkt_i_tlast,
    input  logic [USER_WIDTH-1:0] pkt_i_tuser,
    input  logic [DEST_WIDTH-1:0] pkt_i_tdest,
    input  logic [ID_WIDTH-1:0]   pkt_i_tid,

    output logic                  pkt_o_tvalid,
    input  logic                  pkt_o_tready,
    output logic [DATA_WIDTH-1:0] pkt_o_tdata,
    output logic [KEEP_WIDTH-1:0] pkt_o_tstrb,
    output logic [KEEP_WIDTH-1:0] pkt_o_tkeep,
    output logic                  pkt_o_tlast,
    output logic [USER_WIDTH-1:0] pkt_o_tuser,
    output logic [DEST_WIDTH-1:0] pkt_o_tdest,
    output logic [ID_WIDTH-1:0]   pkt_o_tid,

    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  drop_o,
    output logic [15:0]           drop_cnt_o,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic [ADDR_WIDTH:0]   pkts_amount_o
);

    localparam int                c_word_width = DATA_WIDTH + 2 * KEEP_WIDTH + 1
                                               + USER_WIDTH + DEST_WIDTH + ID_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth    = (ADDR_WIDTH + 1)'(WORDS_AMOUNT);
    localparam logic [ADDR_WIDTH:0] c_af_lvl   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);
    localparam logic [ADDR_WIDTH:0] c_ptr_one  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } wr_state_t;

    logic [c_word_width-1:0] r_mem [WORDS_AMOUNT];
    logic [c_word_width-1:0] r_ram_q;
    logic [c_word_width-1:0] r_out;
    logic [c_word_width-1:0] w_in_word;

    logic [ADDR_WIDTH:0] r_wr_spec;
    logic [ADDR_WIDTH:0] r_wr_commit;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_fetch_ptr;
    logic [ADDR_WIDTH:0] r_pkts;
    logic [ADDR_WIDTH:0] w_used;
    logic [ADDR_WIDTH:0] w_rd_limit;

    wr_state_t   r_state;
    logic        r_q_vld;
    logic        r_out_vld;
    logic        r_drop;
    logic [15:0] r_drop_cnt;

    logic w_full;
    logic w_in_hs;
    logic w_out_hs;
    logic w_wr_en;
    logic w_advance;
    logic w_commit;
    logic w_rewind;
    logic w_drop;
    logic w_avail;
    logic w_rd_en;
    logic w_out_load;

    assign w_in_word = {pkt_i_tid, pkt_i_tdest, pkt_i_tuser, pkt_i_tlast,
                        pkt_i_tkeep, pkt_i_tstrb, pkt_i_tdata};

    // Occupancy counts everything from the read pointer up to the speculative
    // write pointer, so words sitting in the read pipeline still hold their slot.
    assign w_used       = r_wr_spec - r_rd_ptr;
    assign w_full       = (w_used == c_depth);
    assign pkt_i_tready = (MODE == 0) ? !w_full : 1'b1;
    assign w_in_hs      = pkt_i_tvalid && pkt_i_tready;
    assign w_out_hs     = r_out_vld && pkt_o_tready;

    always_comb begin
        w_wr_en   = 1'b0;
        w_advance = 1'b0;
        w_commit  = 1'b0;
        w_rewind  = 1'b0;
        w_drop    = 1'b0;
        if (MODE == 0) begin
            w_wr_en   = w_in_hs;
            w_advance = w_in_hs;
            w_commit  = w_in_hs && pkt_i_tlast;
        end else if (pkt_i_tvalid && (r_state != S_DROP)) begin
            if (w_full) begin
                w_rewind = 1'b1;
                w_drop   = 1'b1;
            end else begin
                w_wr_en = 1'b1;
                if (pkt_i_tlast && (MODE == 2) && pkt_i_tuser[0]) begin
                    w_rewind = 1'b1;
                    w_drop   = 1'b1;
                end else begin
                    w_advance = 1'b1;
                    w_commit  = pkt_i_tlast;
                end
            end
        end
    end

    // Write-side FSM, pointers and packet/drop bookkeeping
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_pkts      <= '0;
            r_drop      <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_drop <= w_drop;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_rewind) begin
                r_wr_spec <= r_wr_commit;
            end else if (w_advance) begin
                r_wr_spec <= r_wr_spec + c_ptr_one;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_spec + c_ptr_one;
            end
            if (w_out_hs) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_commit, w_out_hs && pkt_o_tlast})
                2'b10:   r_pkts <= r_pkts + c_ptr_one;
                2'b01:   r_pkts <= r_pkts - c_ptr_one;
                default: r_pkts <= r_pkts;
            endcase
            if ((MODE != 0) && pkt_i_tvalid) begin
                case (r_state)
                    S_DROP: begin
                        if (pkt_i_tlast) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        if (pkt_i_tlast) begin
                            r_state <= S_IDLE;
                        end else if (w_full) begin
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_ACTIVE;
                        end
                    end
                endcase
            end
        end
    end

    // Store-and-forward modes only expose words below the commit pointer.
    assign w_rd_limit = (MODE == 0) ? r_wr_spec : r_wr_commit;
    assign w_avail    = (r_fetch_ptr != w_rd_limit);
    assign w_out_load = r_q_vld && (!r_out_vld || pkt_o_tready);
    assign w_rd_en    = w_avail && (!r_q_vld || w_out_load);

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_spec[ADDR_WIDTH-1:0]] <= w_in_word;
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_fetch_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fetch_ptr <= '0;
            r_q_vld     <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out       <= '0;
        end else begin
            if (w_rd_en) begin
                r_fetch_ptr <= r_fetch_ptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_q_vld <= 1'b1;
            end else if (w_out_load) begin
                r_q_vld <= 1'b0;
            end
            if (w_out_load) begin
                r_out_vld <= 1'b1;
                r_out     <= r_ram_q;
            end else if (w_out_hs) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign {pkt_o_tid, pkt_o_tdest, pkt_o_tuser, pkt_o_tlast,
            pkt_o_tkeep, pkt_o_tstrb, pkt_o_tdata} = r_out;

    assign pkt_o_tvalid  = r_out_vld;
    assign full_o        = w_full;
    assign empty_o       = !r_out_vld;
    assign almost_full_o = (w_used >= c_af_lvl);
    assign drop_o        = r_drop;
    assign drop_cnt_o    = r_drop_cnt;
    assign used_words_o  = w_used;
    assign pkts_amount_o = r_pkts;

endmodule

`default_nettype wire

// File: tb/tb_axi4_stream_pkt_fifo_v2.sv
// Testbench for axi4_stream_pkt_fifo_v2: one instance per MODE (0, 1, 2), directed
// vectors plus a randomized run against a queue-based packet model.
`default_nettype none

module tb_axi4_stream_pkt_fifo_v2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid [3];
    logic        in_ready [3];
    logic [31:0] in_data  [3];
    logic [3:0]  in_strb  [3];
    logic [3:0]  in_keep  [3];
    logic        in_last  [3];
    logic [0:0]  in_user  [3];
    logic [0:0]  in_dest  [3];
    logic [0:0]  in_id    [3];
    logic        out_valid[3];
    logic        out_ready[3];
    logic [31:0] out_data [3];
    logic [3:0]  out_strb [3];
    logic [3:0]  out_keep [3];
    logic        out_last [3];
    logic [0:0]  out_user [3];
    logic [0:0]  out_dest [3];
    logic [0:0]  out_id   [3];
    logic        full     [3];
    logic        empty    [3];
    logic        afull    [3];
    logic        drop     [3];
    logic [15:0] drop_cnt [3];
    logic [3:0]  used     [3];
    logic [3:0]  pkts     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi4_stream_pkt_fifo_v2 #(.MODE(g)) u_dut (
            .clk_i         (clk),
            .rst_n_i       (rst_n),
            .pkt_i_tvalid  (in_valid[g]),
            .pkt_i_tready  (in_ready[g]),
            .pkt_i_tdata   (in_data[g]),
            .pkt_i_tstrb   (in_strb[g]),
            .pkt_i_tkeep   (in_keep[g]),
            .pkt_i_tlast   (in_last[g]),
            .pkt_i_tuser   (in_user[g]),
            .pkt_i_tdest   (in_dest[g]),
            .pkt_i_tid     (in_id[g]),
            .pkt_o_tvalid  (out_valid[g]),
            .pkt_o_tready  (out_ready[g]),
            .pkt_o_tdata   (out_data[g]),
            .pkt_o_tstrb   (out_strb[g]),
            .pkt_o_tkeep   (out_keep[g]),
            .pkt_o_tlast   (out_last[g]),
            .pkt_o_tuser   (out_user[g]),
            .pkt_o_tdest   (out_dest[g]),
            .pkt_o_tid     (out_id[g]),
            .full_o        (full[g]),
            .empty_o       (empty[g]),
            .almost_full_o (afull[g]),
            .drop_o        (drop[g]),
            .drop_cnt_o    (drop_cnt[g]),
            .used_words_o  (used[g]),
            .pkts_amount_o (pkts[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic v, input logic [31:0] d, input logic l, input logic u);
        in_valid[m] = v;
        in_data[m]  = d;
        in_last[m]  = l;
        in_user[m]  = u;
        in_keep[m]  = d[3:0];
        in_strb[m]  = d[7:4];
        in_id[m]    = d[8];
        in_dest[m]  = d[9];
    endtask

    // Directed vector record for the MODE 0 fill/drain sequence
    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        rdy;
        int          used;
        logic        full;
        logic        af;
        logic        irdy;
        logic        ov;
        logic [31:0] od;
        int          pkts;
    } vec_t;

    function automatic vec_t mk(input int v, input int d, input int l, input int rdy, input int u,
                                input int f, input int af, input int ir, input int ov,
                                input int od, input int p);
        vec_t r;
        r.v = 1'(v); r.d = 32'(d); r.l = 1'(l); r.rdy = 1'(rdy); r.used = u;
        r.full = 1'(f); r.af = 1'(af); r.irdy = 1'(ir); r.ov = 1'(ov); r.od = 32'(od); r.pkts = p;
        return r;
    endfunction

    // Reference model state: expected output words {user, last, data} per instance
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];
    logic [33:0] open2[$];
    int          mdl_used[3];
    int          mdl_pkts[3];
    int          exp_drops;
    int          rem2;
    bit          bad2;
    int          seq;

    function automatic void push_exp(input int m, input logic [33:0] x);
        case (m)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endfunction

    function automatic int q_size(input int m);
        case (m)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [33:0] pop_exp(input int m);
        case (m)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic rnd_cycle(input bit produce);
        logic [33:0] x;
        logic [31:0] d;
        logic        v;
        logic        l;
        logic        u;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rnd used m%0d", m), 64'(used[m]), 64'(mdl_used[m]));
            chk($sformatf("rnd pkts m%0d", m), 64'(pkts[m]), 64'(mdl_pkts[m]));
        end
        for (int m = 0; m < 3; m++) begin
            out_ready[m] = produce ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid[m] && out_ready[m]) begin
                if (q_size(m) == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rnd unexpected beat m%0d: got data=%0h expected no beat", m, out_data[m]);
                end else begin
                    x = pop_exp(m);
                    chk($sformatf("rnd data m%0d", m), 64'(out_data[m]), 64'(x[31:0]));
                    chk($sformatf("rnd last m%0d", m), 64'(out_last[m]), 64'(x[32]));
                    chk($sformatf("rnd user m%0d", m), 64'(out_user[m]), 64'(x[33]));
                    chk($sformatf("rnd side m%0d", m),
                        64'({out_id[m], out_dest[m], out_strb[m], out_keep[m]}),
                        64'({x[8], x[9], x[7:4], x[3:0]}));
                    mdl_used[m]--;
                    if (x[32]) mdl_pkts[m]--;
                end
            end
        end
        // MODE 0: free-running producer relying on tready backpressure
        v = produce && ($urandom_range(0, 1) == 1);
        d = 32'(seq); seq++;
        l = ($urandom_range(0, 2) == 0);
        drive(0, v, d, l, d[10]);
        if (v && in_ready[0]) begin
            push_exp(0, {d[10], l, d});
            mdl_used[0]++;
            if (l) mdl_pkts[0]++;
        end
        // MODE 1: single-word packets, producer waits while full
        v = produce && !full[1] && ($urandom_range(0, 1) == 1);
        d = 32'(seq); seq++;
        drive(1, v, d, 1'b1, d[10]);
        if (v) begin
            push_exp(1, {d[10], 1'b1, d});
            mdl_used[1]++;
            mdl_pkts[1]++;
        end
        // MODE 2: 1..4 word packets, a quarter flagged bad on tlast
        if (produce && rem2 == 0 && $urandom_range(0, 1) == 1) begin
            rem2 = $urandom_range(1, 4);
            bad2 = ($urandom_range(0, 3) == 0);
        end
        if (rem2 > 0 && !full[2] && $urandom_range(0, 1) == 1) begin
            l = (rem2 == 1);
            u = l && bad2;
            d = 32'(seq); seq++;
            drive(2, 1'b1, d, l, u);
            rem2--;
            if (!(l && bad2)) begin
                open2.push_back({u, l, d});
                mdl_used[2]++;
            end
            if (l) begin
                if (bad2) begin
                    mdl_used[2] -= open2.size();
                    exp_drops++;
                end else begin
                    foreach (open2[i]) q2.push_back(open2[i]);
                    mdl_pkts[2]++;
                end
                open2.delete();
            end
        end else begin
            drive(2, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        tick();
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17];
        int   pulses;
        int   pk_max;
        bit   ov_seen;
        logic [31:0] beats[$];

        for (int m = 0; m < 3; m++) begin
            drive(m, 1'b0, 32'd0, 1'b0, 1'b0);
            out_ready[m] = 1'b0;
            mdl_used[m]  = 0;
            mdl_pkts[m]  = 0;
        end
        exp_drops = 0; rem2 = 0; bad2 = 0; seq = 32'h1000;

        // MODE 0 fill to full with the sink stalled, then drain in order
        tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 2, 0, 0, 3, 0, 0, 1, 1, 0, 0);
        tbl[3]  = mk(1, 3, 1, 0, 4, 0, 0, 1, 1, 0, 1);
        tbl[4]  = mk(1, 4, 0, 0, 5, 0, 0, 1, 1, 0, 1);
        tbl[5]  = mk(1, 5, 0, 0, 6, 0, 1, 1, 1, 0, 1);
        tbl[6]  = mk(1, 6, 0, 0, 7, 0, 1, 1, 1, 0, 1);
        tbl[7]  = mk(1, 7, 1, 0, 8, 1, 1, 0, 1, 0, 2);
        tbl[8]  = mk(1, 8, 0, 0, 8, 1, 1, 0, 1, 0, 2);
        tbl[9]  = mk(0, 0, 0, 1, 7, 0, 1, 1, 1, 1, 2);
        tbl[10] = mk(0, 0, 0, 1, 6, 0, 1, 1, 1, 2, 2);
        tbl[11] = mk(0, 0, 0, 1, 5, 0, 0, 1, 1, 3, 2);
        tbl[12] = mk(0, 0, 0, 1, 4, 0, 0, 1, 1, 4, 1);
        tbl[13] = mk(0, 0, 0, 1, 3, 0, 0, 1, 1, 5, 1);
        tbl[14] = mk(0, 0, 0, 1, 2, 0, 0, 1, 1, 6, 1);
        tbl[15] = mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 7, 1);
        tbl[16] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state on every instance
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rst tvalid m%0d", m), 64'(out_valid[m]), 64'(0));
            chk($sformatf("rst empty m%0d", m), 64'(empty[m]), 64'(1));
            chk($sformatf("rst full m%0d", m), 64'(full[m]), 64'(0));
            chk($sformatf("rst afull m%0d", m), 64'(afull[m]), 64'(0));
            chk($sformatf("rst drop m%0d", m), 64'(drop[m]), 64'(0));
            chk($sformatf("rst dropcnt m%0d", m), 64'(drop_cnt[m]), 64'(0));
            chk($sformatf("rst used m%0d", m), 64'(used[m]), 64'(0));
            chk($sformatf("rst pkts m%0d", m), 64'(pkts[m]), 64'(0));
            chk($sformatf("rst tready m%0d", m), 64'(in_ready[m]), 64'(1));
        end

        for (int r = 0; r < 17; r++) begin
            drive(0, tbl[r].v, tbl[r].d, tbl[r].l, 1'b0);
            out_ready[0] = tbl[r].rdy;
            tick();
            chk($sformatf("m0 row%0d used", r), 64'(used[0]), 64'(tbl[r].used));
            chk($sformatf("m0 row%0d full", r), 64'(full[0]), 64'(tbl[r].full));
            chk($sformatf("m0 row%0d afull", r), 64'(afull[0]), 64'(tbl[r].af));
            chk($sformatf("m0 row%0d tready", r), 64'(in_ready[0]), 64'(tbl[r].irdy));
            chk($sformatf("m0 row%0d tvalid", r), 64'(out_valid[0]), 64'(tbl[r].ov));
            chk($sformatf("m0 row%0d empty", r), 64'(empty[0]), 64'(!tbl[r].ov));
            chk($sformatf("m0 row%0d pkts", r), 64'(pkts[0]), 64'(tbl[r].pkts));
            if (tbl[r].ov) chk($sformatf("m0 row%0d data", r), 64'(out_data[0]), 64'(tbl[r].od));
        end
        drive(0, 1'b0, 32'd0, 1'b0, 1'b0);

        // MODE 1: 3-word packet, latency and contiguous delivery
        out_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 32'(100 + i), 1'(i == 2), 1'b0);
            tick();
            if (i == 1) begin
                chk("m1 pre-commit used", 64'(used[1]), 64'(2));
                chk("m1 pre-commit pkts", 64'(pkts[1]), 64'(0));
            end
        end
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("m1 commit used", 64'(used[1]), 64'(3));
        chk("m1 commit pkts", 64'(pkts[1]), 64'(1));
        chk("m1 commit tvalid", 64'(out_valid[1]), 64'(0));
        tick();
        chk("m1 k+1 tvalid", 64'(out_valid[1]), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("m1 beat%0d tvalid", i), 64'(out_valid[1]), 64'(1));
            chk($sformatf("m1 beat%0d data", i), 64'(out_data[1]), 64'(100 + i));
            chk($sformatf("m1 beat%0d last", i), 64'(out_last[1]), 64'(i == 2));
        end
        chk("m1 before last pop pkts", 64'(pkts[1]), 64'(1));
        tick();
        chk("m1 drained tvalid", 64'(out_valid[1]), 64'(0));
        chk("m1 drained used", 64'(used[1]), 64'(0));
        chk("m1 drained pkts", 64'(pkts[1]), 64'(0));

        // MODE 1: oversize packet is dropped at the 9th word
        pulses = 0; ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'b1, 32'(200 + i), 1'(i == 9), 1'b0);
            tick();
            pulses += int'(drop[1]);
            ov_seen |= out_valid[1];
            if (i == 7) begin
                chk("m1 long used at 8", 64'(used[1]), 64'(8));
                chk("m1 long full at 8", 64'(full[1]), 64'(1));
                chk("m1 long no drop yet", 64'(drop[1]), 64'(0));
            end
            if (i == 8) begin
                chk("m1 long drop pulse", 64'(drop[1]), 64'(1));
                chk("m1 long rewind used", 64'(used[1]), 64'(0));
                chk("m1 long dropcnt", 64'(drop_cnt[1]), 64'(1));
            end
        end
        chk("m1 long tvalid never", 64'(ov_seen), 64'(0));
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'b1, 32'(300 + i), 1'(i == 1), 1'b0);
            tick();
            pulses += int'(drop[1]);
        end
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("m1 after long k+1 tvalid", 64'(out_valid[1]), 64'(0));
        for (int i = 0; i < 2; i++) begin
            tick();
            pulses += int'(drop[1]);
            chk($sformatf("m1 after long beat%0d data", i), 64'(out_data[1]), 64'(300 + i));
            chk($sformatf("m1 after long beat%0d valid", i), 64'(out_valid[1]), 64'(1));
        end
        tick();
        chk("m1 single drop pulse", 64'(pulses), 64'(1));
        chk("m1 dropcnt final", 64'(drop_cnt[1]), 64'(1));
        chk("m1 empty again", 64'(used[1]), 64'(0));

        // MODE 2: errored frame discarded, good frame delivered
        out_ready[2] = 1'b1;
        pk_max = 0;
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b1, 32'(400 + i), 1'(i == 3), 1'(i == 3));
            tick();
        end
        chk("m2 bad drop pulse", 64'(drop[2]), 64'(1));
        chk("m2 bad dropcnt", 64'(drop_cnt[2]), 64'(1));
        chk("m2 bad used", 64'(used[2]), 64'(0));
        chk("m2 bad pkts", 64'(pkts[2]), 64'(0));
        for (int i = 0; i < 4; i++) begin
            drive(2, 1'b1, 32'(410 + i), 1'(i == 3), 1'b0);
            tick();
            if (int'(pkts[2]) > pk_max) pk_max = int'(pkts[2]);
            if (out_valid[2]) beats.push_back(out_data[2]);
        end
        drive(2, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (int'(pkts[2]) > pk_max) pk_max = int'(pkts[2]);
            if (out_valid[2]) beats.push_back(out_data[2]);
        end
        chk("m2 beat count", 64'(beats.size()), 64'(4));
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            chk($sformatf("m2 beat%0d data", i), 64'(beats[i]), 64'(410 + i));
        end
        chk("m2 pkts peak", 64'(pk_max), 64'(1));
        chk("m2 dropcnt after good", 64'(drop_cnt[2]), 64'(1));

        // Reset mid-packet: 5 words held in MODE 0 and MODE 1
        out_ready[0] = 1'b0;
        out_ready[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, 32'(600 + i), 1'b0, 1'b0);
            drive(1, 1'b1, 32'(700 + i), 1'b0, 1'b0);
            tick();
        end
        chk("pre-reset m0 tvalid", 64'(out_valid[0]), 64'(1));
        chk("pre-reset m0 used", 64'(used[0]), 64'(5));
        chk("pre-reset m1 used", 64'(used[1]), 64'(5));
        #2;
        rst_n = 1'b0;
        for (int m = 0; m < 3; m++) drive(m, 1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("async rst m0 used", 64'(used[0]), 64'(0));
        chk("async rst m0 tvalid", 64'(out_valid[0]), 64'(0));
        chk("async rst m1 used", 64'(used[1]), 64'(0));
        chk("async rst m1 dropcnt", 64'(drop_cnt[1]), 64'(0));
        chk("async rst m2 dropcnt", 64'(drop_cnt[2]), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        out_ready[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1'b1, 32'(800 + i), 1'(i == 1), 1'b0);
            tick();
        end
        drive(1, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("post-rst beat%0d valid", i), 64'(out_valid[1]), 64'(1));
            chk($sformatf("post-rst beat%0d data", i), 64'(out_data[1]), 64'(800 + i));
        end
        tick();
        chk("post-rst drained", 64'(used[1]), 64'(0));

        // Randomized traffic on all three modes against the queue model
        for (int c = 0; c < 700; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 80; c++) rnd_cycle(1'b0);
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("rnd leftover m%0d", m), 64'(q_size(m)), 64'(0));
            chk($sformatf("rnd final used m%0d", m), 64'(used[m]), 64'(0));
        end
        chk("rnd m1 dropcnt", 64'(drop_cnt[1]), 64'(0));
        chk("rnd m2 dropcnt", 64'(drop_cnt[2]), 64'(exp_drops));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi4_stream_pkt_fifo_v2.md
Name: axi4_stream_pkt_fifo_v2

Overview:
Single-clock AXI4-Stream FIFO and the parametrised successor of the team's packet FIFO. It supports three run-time-fixed modes: passthrough with backpressure, store-and-forward with overflow drop, and store-and-forward that also drops errored frames. Write-side commit/rewind pointers replace word-count arithmetic. Adds almost-full threshold, saturating drop counter and error-frame discard. It sits between stream producers (MAC/DMA) and consumers.

Parameters:
DATA_WIDTH, 32, tdata width (multiple of 8); tstrb/tkeep width = DATA_WIDTH/8
USER_WIDTH, 1, tuser width; tuser[0] is the bad-frame flag, sampled with tlast
DEST_WIDTH, 1, tdest width
ID_WIDTH, 1, tid width
WORDS_AMOUNT, 8, RAM depth in words; power of two, >= 4
MODE, 1, 0 = passthrough/backpressure; 1 = store-and-forward, drop on overflow; 2 = MODE 1 plus drop on tuser[0] at tlast
ALMOST_FULL_LVL, WORDS_AMOUNT-2, almost_full_o threshold in words
ADDR_WIDTH, $clog2(WORDS_AMOUNT), derived

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; asynchronous, active-low
full_o  out  1  used_words_o == WORDS_AMOUNT
empty_o  out  1  no word held at output register
almost_full_o  out  1  used_words_o >= ALMOST_FULL_LVL
drop_o  out  1  one-cycle pulse per dropped packet
drop_cnt_o  out  16  dropped packets, saturates at 16'hFFFF
used_words_o  out  ADDR_WIDTH+1  words stored, committed plus uncommitted, including output register
pkts_amount_o  out  ADDR_WIDTH+1  committed packets not yet fully read
pkt_i  axi4_stream_if.slave  -  input stream
pkt_o  axi4_stream_if.master  -  output stream

Behaviour:
- Reset (rst_n_i low, asynchronous): all pointers and counters 0; write FSM in IDLE. Outputs: pkt_o.tvalid=0, empty_o=1, full_o=0, almost_full_o=0 (ALMOST_FULL_LVL>0), drop_o=0, drop_cnt_o=0, used_words_o=0, pkts_amount_o=0. Reset mid-packet discards all contents; there is no partial-packet recovery.
- Pointers are ADDR_WIDTH+1 bits with a wrap bit: wr_spec (next write), wr_commit (start of the open packet), rd_ptr. used_words_o = wr_spec - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- MODE 0: pkt_i.tready = !full_o. A word is readable as soon as it is written. pkts_amount_o still counts tlast words in minus tlast words out. Drops never occur.
- MODE 1/2: pkt_i.tready = 1 at all times. A word accepted at edge k is written at wr_spec, and wr_spec increments.
- Write FSM (MODE 1/2): IDLE -> ACTIVE on first accepted word without tlast. ACTIVE -> IDLE on good tlast. ACTIVE/IDLE -> DROP when tvalid arrives with full_o=1 and the word is not tlast. A tlast word with full_o=1 is also dropped, with no DROP entry. DROP -> IDLE on accepted tlast; in DROP, words are accepted and discarded.
- Commit: on good tlast (MODE 2 requires tuser[0]=0), wr_commit <= wr_spec+1 and pkts_amount_o increments.
- Drop: wr_spec <= wr_commit (rewind). drop_o pulses once per packet, at drop detection; drop_cnt_o increments (saturating). MODE 2 bad tlast is a drop.
- Packet longer than WORDS_AMOUNT is always dropped in MODE 1/2.
- Read side: synchronous RAM plus one output register (prefetch). MODE 1/2: words are readable only below wr_commit. pkt_o.tvalid stays high across a whole committed packet until its tlast is read.
- Latency, empty FIFO: MODE 0 word accepted at edge k gives pkt_o.tvalid=1 after edge k+2. MODE 1/2 tlast accepted at edge k gives the packet's first word valid after edge k+2.
- Throughput: one word per clock in each direction, sustained. Simultaneous read and write leaves used_words_o unchanged.
- Simultaneous commit and last-word read: pkts_amount_o unchanged.
- Simultaneous rewind and read: used_words_o = old - discarded - 1.
- Output stability: pkt_o payload holds while tvalid && !tready.

Test Plan:
1. WORDS_AMOUNT=8, MODE=1, 3-word packet, tready=1 -> tvalid after edge k+2 of tlast; 3 contiguous beats; pkts_amount_o 1->0; used_words_o returns to 0.
2. MODE=1, 10-word packet into empty FIFO -> drop_o one pulse at the 9th word, drop_cnt_o=1, used_words_o=0, pkt_o.tvalid never asserts; next 2-word packet passes intact.
3. MODE=2, 4-word packet with tuser[0]=1 on tlast, then 4-word good packet -> first dropped (drop_cnt_o=1); only the second appears; pkts_amount_o peaks at 1.
4. MODE=0, pkt_o.tready=0, 8 words written -> full_o=1, pkt_i.tready=0, almost_full_o=1 from 6 words; release tready -> 8 words in order, full_o clears after the first read.
5. MODE=1, continuous 1-word packets with tready toggling 50% across 3 pointer wraps -> no loss, order preserved, used_words_o never exceeds 8.
6. Reset asserted mid-packet with 5 words stored -> immediate used_words_o=0, pkt_o.tvalid=0, drop_cnt_o=0; post-reset packet is delivered normally.
